// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: show-ahead FIFO pop port.
// master = FIFO side, slave = consumer side.
interface fifo_uart_tx_if #(
   parameter int bW = 8
);
   logic [bW-1:0] popData;
   logic          empty;
   logic          pop;

   modport master (
      output popData,
      output empty,
      input  pop
   );

   modport slave (
      input  popData,
      input  empty,
      output pop
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a show-ahead FIFO onto a UART line.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit.
module fifo_uart_tx #(
   parameter int bW           = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic          clk,
   input  logic          rst,
   fifo_uart_tx_if.slave fifo,
   input  logic          tx_en,
   output logic          tx,
   output logic          busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int NW = (bW > 2) ? $clog2(bW) : 1;

   localparam logic [CW-1:0] BMAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [NW-1:0] DMAX = NW'(bW - 1);
   localparam logic [NW-1:0] SMAX = NW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t        state, nstate;
   logic [CW-1:0] bcnt, nbcnt;
   logic [NW-1:0] bitcnt, nbit;
   logic [bW-1:0] sh, nsh;
   logic          ntx;
   logic          wrap;
   logic          last;

   assign wrap = (bcnt == BMAX);
   assign last = (state == STOP) && wrap && (bitcnt == SMAX);

   // Pop may overlap the final stop cycle so frames run back to back.
   assign fifo.pop = !rst && tx_en && !fifo.empty &&
                     ((state == IDLE) || last);

`ifdef FIFO_UART_TX_PARITY_EN
   logic par;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par <= 1'b0;
      end else if (fifo.pop) begin
         par <= ^fifo.popData;
      end
   end
`endif

   always_comb begin
      nstate = state;
      nbcnt  = bcnt;
      nbit   = bitcnt;
      nsh    = sh;
      if (state != IDLE) begin
         nbcnt = wrap ? '0 : bcnt + 1'b1;
      end
      unique case (state)
         IDLE: begin
            if (fifo.pop) begin
               nstate = START;
               nsh    = fifo.popData;
               nbcnt  = '0;
               nbit   = '0;
            end
         end
         START: begin
            if (wrap) nstate = DATA;
         end
         DATA: begin
            if (wrap) begin
               nsh  = sh >> 1;
               nbit = bitcnt + 1'b1;
               if (bitcnt == DMAX) begin
                  nbit = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                  nstate = PARITY;
`else
                  nstate = STOP;
`endif
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: begin
            if (wrap) nstate = STOP;
         end
`endif
         STOP: begin
            if (wrap) begin
               nbit = bitcnt + 1'b1;
               if (bitcnt == SMAX) begin
                  nbit   = '0;
                  nstate = fifo.pop ? START : IDLE;
                  if (fifo.pop) nsh = fifo.popData;
               end
            end
         end
         default: nstate = IDLE;
      endcase

      ntx = 1'b1;
      case (nstate)
         START:   ntx = 1'b0;
         DATA:    ntx = nsh[0];
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY:  ntx = par;
`endif
         default: ntx = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         bcnt   <= '0;
         bitcnt <= '0;
         sh     <= '0;
         tx     <= 1'b1;
         busy   <= 1'b0;
      end else begin
         state  <= nstate;
         bcnt   <= nbcnt;
         bitcnt <= nbit;
         sh     <= nsh;
         tx     <= ntx;
         busy   <= (nstate != IDLE);
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: random and directed frames vs a bit-stream model.
// The model expands each popped byte into its per-cycle tx levels.
module tb_fifo_uart_tx;
   localparam int BW  = 8;
   localparam int CPB = 16;
   localparam int SB  = 1;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FRAME = (1 + BW + P + SB) * CPB;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic tx_en = 1'b0;
   logic tx;
   logic busy;

   fifo_uart_tx_if #(.bW(BW)) fif ();

   fifo_uart_tx #(
      .bW(BW),
      .CLKS_PER_BIT(CPB),
      .STOP_BITS(SB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fifo(fif),
      .tx_en(tx_en),
      .tx(tx),
      .busy(busy)
   );

   always #5 clk = ~clk;

   logic [7:0] fq[$];
   bit         exq[$];
   int         checks = 0;
   int         errors = 0;
   int         npops = 0;
   int         busycnt = 0;
   int         run = 0;
   int         maxrun = 0;
   int         pushed = 0;
   bit         popq = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_fifo();
      fif.empty   = (fq.size() == 0);
      fif.popData = (fq.size() != 0) ? fq[0] : 8'($urandom);
   endtask

   function automatic void push_frame(input logic [7:0] d);
      bit b[$];
      b.push_back(1'b0);
      for (int i = 0; i < BW; i++) b.push_back(d[i]);
`ifdef FIFO_UART_TX_PARITY_EN
      b.push_back(^d);
`endif
      for (int i = 0; i < SB; i++) b.push_back(1'b1);
      foreach (b[i]) repeat (CPB) exq.push_back(b[i]);
   endfunction

   // Model: per-cycle expected tx/busy/pop, checked on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            exq.delete();
            popq = 1'b0;
            run  = 0;
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_pop", fif.pop, 0);
         end else begin
            int   n;
            bit   e;
            logic ep;
            n = exq.size();
            e = (n > 0) ? exq.pop_front() : 1'b1;
            chk("tx", tx, e);
            chk("busy", busy, (n > 0));
            ep = tx_en && (fq.size() > 0) && (n <= 1);
            chk("pop", fif.pop, ep);
            if (n > 0) begin
               busycnt++;
               run++;
               if (run > maxrun) maxrun = run;
            end else begin
               run = 0;
            end
            popq = fif.pop;
            if (fif.pop && fq.size() > 0) push_frame(fq[0]);
         end
      end
   end

   // FIFO side: consume the head on the edge where pop was high.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (popq && fq.size() > 0) begin
            void'(fq.pop_front());
            npops++;
         end
         popq = 1'b0;
         drive_fifo();
      end
   end

   task automatic wait_idle(input int lim);
      int k;
      k = 0;
      while ((fq.size() != 0 || exq.size() != 0) && k < lim) begin
         @(posedge clk);
         k++;
      end
      chk("idle_timeout", (k < lim), 1);
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic wait_pop(input int lim);
      int k;
      k = 0;
      while (npops == 0 && k < lim) begin
         @(posedge clk);
         #2;
         k++;
      end
      chk("pop_timeout", (k < lim), 1);
   endtask

   initial begin
      drive_fifo();
      #1 rst = 1'b1;
      fq.push_back(8'hA5);
      drive_fifo();
      tx_en = 1'b1;
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      #1 chk("rel_pop", fif.pop, 1);
      wait_idle(FRAME + 50);

      npops = 0;
      busycnt = 0;
      fq.push_back(8'h35);
      drive_fifo();
      wait_idle(FRAME + 50);
      chk("single_pops", npops, 1);
      chk("single_busy", busycnt, FRAME);
      chk("single_idle_tx", tx, 1);

      npops = 0;
      busycnt = 0;
      maxrun = 0;
      fq.push_back(8'h05);
      fq.push_back(8'h04);
      fq.push_back(8'h03);
      drive_fifo();
      wait_idle(3 * FRAME + 50);
      chk("b2b_pops", npops, 3);
      chk("b2b_busy", busycnt, 3 * FRAME);
      chk("b2b_run", maxrun, 3 * FRAME);

      npops = 0;
      fq.push_back(8'h11);
      fq.push_back(8'h22);
      drive_fifo();
      wait_pop(20);
      repeat (50) @(posedge clk);
      #2 tx_en = 1'b0;
      repeat (FRAME) @(posedge clk);
      #2;
      chk("en_pops", npops, 1);
      chk("en_left", fq.size(), 1);
      chk("en_busy", busy, 0);
      tx_en = 1'b1;
      @(negedge clk);
      #1 chk("en_repop", fif.pop, 1);
      wait_idle(FRAME + 50);
      chk("en_pops2", npops, 2);

      npops = 0;
      fq.push_back(8'hFF);
      fq.push_back(8'h5A);
      drive_fifo();
      wait_pop(20);
      repeat (70) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_pop", fif.pop, 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      wait_idle(FRAME + 50);
      chk("rst_pops", npops, 2);
      chk("rst_left", fq.size(), 0);

      npops = 0;
      busycnt = 0;
      fq.push_back(8'h07);
      fq.push_back(8'h03);
      drive_fifo();
      wait_idle(2 * FRAME + 50);
      chk("pair_pops", npops, 2);
      chk("pair_busy", busycnt, 2 * FRAME);

      npops = 0;
      pushed = 0;
      for (int r = 0; r < 30; r++) begin
         int nb;
         nb = $urandom_range(1, 3);
         for (int j = 0; j < nb; j++) fq.push_back(8'($urandom));
         pushed += nb;
         drive_fifo();
         repeat ($urandom_range(0, 2 * FRAME)) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 99) < 2) tx_en = ~tx_en;
         end
      end
      tx_en = 1'b1;
      wait_idle(100 * FRAME);
      chk("rand_pops", npops, pushed);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
